ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
ID/EX pipeline register plus operand-forwarding network for the 5-stage MIPS core; sits directly upstream of the 32-bit ALU and drives its A, B and 3-bit opcode inputs.
Latches decoded instruction fields on each enabled clock edge and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
Detects load-use hazards and requests a one-cycle stall from the hazard/PC logic.

Parameters:
DATA_W, 32, datapath width; must stay 32 to match the ALU.
REG_AW, 5, register-address width (32 architectural registers).

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  synchronous, active-high reset.
id_valid  in  1  ID holds a real instruction.
id_rs_addr, id_rt_addr, id_rd_addr  in  REG_AW each  source and destination register numbers.
id_rs_data, id_rt_data  in  DATA_W each  register-file read data.
id_imm  in  DATA_W  immediate, already sign- or zero-extended.
id_shamt  in  5  shift amount.
id_alu_op  in  3  ALU opcode.
id_src_b_sel  in  2  B select: 00 rt, 01 imm, 10 shamt zero-extended, 11 reserved (treated as rt).
id_reg_write, id_mem_read  in  1 each  writeback enable; instruction is a load.
id_uses_rt  in  1  instruction reads rt.
stall  in  1  hold EX register contents.
flush  in  1  load a bubble into EX.
exm_reg_write  in  1  EX/MEM writeback enable.
exm_rd  in  REG_AW  EX/MEM destination register.
exm_result  in  DATA_W  EX/MEM result.
wb_reg_write  in  1  MEM/WB writeback enable.
wb_rd  in  REG_AW  MEM/WB destination register.
wb_result  in  DATA_W  MEM/WB result.
alu_a, alu_b  out  DATA_W each  ALU operands.
alu_opcode  out  3  ALU opcode.
ex_valid, ex_reg_write, ex_mem_read  out  1 each  registered controls.
ex_rd  out  REG_AW  registered destination register.
ex_store_data  out  DATA_W  forwarded rt value, used for stores.
load_use_stall  out  1  hazard request to upstream.

Behaviour:
- Reset (rst=1 at edge): every EX register clears to 0: valid, reg_write, mem_read, rd, rs/rt addr, data, imm, shamt, op, src_b_sel. alu_opcode=000, alu_a=alu_b=ex_store_data=0, ex_rd=0, load_use_stall=0 during the cycle after reset. Reset overrides stall and flush.
- Edge priority: rst > flush > stall > load.
  - flush: load a bubble, which clears all fields to 0 (same values as reset).
  - stall: all EX registers hold.
  - load: latch all id_* fields. If id_valid=0, ex_reg_write and ex_mem_read latch as 0.
- Latency: one cycle from ID inputs to the registered fields. Forwarding and operand muxes are combinational on the registered fields plus the current exm_*/wb_* inputs.
- Forwarding, evaluated separately for rs and rt:
  - Use exm_result if exm_reg_write=1, exm_rd!=0 and exm_rd equals the source address.
  - Otherwise use wb_result if wb_reg_write=1, wb_rd!=0 and wb_rd equals the source address.
  - Otherwise use the latched register-file data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand outputs:
  - alu_a = forwarded rs.
  - alu_b per src_b_sel: 00/11 forwarded rt; 01 imm; 10 {27'b0, shamt}.
  - ex_store_data = forwarded rt regardless of src_b_sel.
  - alu_opcode = latched op, passed through unchanged. 011 is passed through; the ALU yields 0 for it.
- Forwarding stays active while stall=1, so operands track the later stages even with EX held.
- load_use_stall is combinational: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs_addr | (id_uses_rt & ex_rd==id_rt_addr)). It is asserted regardless of stall/flush inputs. The external hazard unit converts it into an ID stall plus an EX flush.
- A bubble (ex_valid=0) still drives its outputs, with reg_write=mem_read=0 and opcode 000.

Decomposition:
- Shared package mips_pkg holds:
  - ALU opcode constants: ALU_ADD=000, ALU_SLL=001, ALU_SUB=010, ALU_XOR=100, ALU_SRL=101, ALU_OR=110, ALU_AND=111.
  - B-select constants: SRCB_RT=00, SRCB_IMM=01, SRCB_SHAMT=10.
  - REG_AW and DATA_W.
- One sub-module, fwd_mux, instantiated twice (rs, rt): inputs are source address, latched data and the two forward sources; output is the resolved value.

Test Plan:
- rst=1 for 2 cycles with random id_* inputs -> all outputs 0, load_use_stall=0.
- Load ADD rs=r3 (0x10), rt=r4 (0x20), src_b=00, no forwards -> next cycle alu_a=0x10, alu_b=0x20, alu_opcode=000, ex_valid=1.
- Same instruction with exm_rd=3 (0xAA), wb_rd=3 (0xBB), wb_rd=4 (0xCC), both write enables set -> alu_a=0xAA (EX/MEM priority), alu_b=0xCC. Repeat with exm_rd=0 and exm_result=0xFF -> r0 data is not forwarded.
- SLL with src_b=10, shamt=5, rt data 0x1234 -> alu_b=0x5, ex_store_data=0x1234. ORI with src_b=01, imm=0x0000FFFF -> alu_b=0x0000FFFF, alu_opcode=110.
- EX holds LW rd=7 and ID has rs=7 -> load_use_stall=1. Same with ID rt=7 and id_uses_rt=0 -> 0. Same with ex rd=0 -> 0.
- stall=1 for 3 cycles -> EX fields held while a changing exm_result forwards through each cycle. Then stall=1 and flush=1 together -> bubble: ex_valid=0, ex_reg_write=0. Then rst mid-stall -> all fields cleared.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core datapath.
// Holds datapath widths, ALU opcode and B-operand select encodings, the
// layout of the ID/EX pipeline register, and the forwarding match rule.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // ALU opcodes; 3'b011 is unused and the ALU returns 0 for it.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_RSVD = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  // B operand source; the reserved code behaves like SRCB_RT.
  typedef enum logic [1:0] {
    SRCB_RT    = 2'b00,
    SRCB_IMM   = 2'b01,
    SRCB_SHAMT = 2'b10,
    SRCB_RSVD  = 2'b11
  } srcb_e;

  // Contents of the ID/EX pipeline register. All-zero is a bubble.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [2:0]        op;
    srcb_e             src_b_sel;
  } ex_regs_t;

  // A later stage may forward only when it writes a non-zero register that
  // matches the source; register 0 is hardwired and never forwarded.
  function automatic logic fwdHit(input logic              we,
                                  input logic [REG_AW-1:0] dst,
                                  input logic [REG_AW-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one source register.
// Ports:
//   src_addr_i                    source register number held in EX
//   reg_data_i                    register-file data latched with it
//   exm_reg_write_i/exm_rd_i/exm_result_i  EX/MEM forward source
//   wb_reg_write_i/wb_rd_i/wb_result_i     MEM/WB forward source
//   fwd_data_o                    resolved operand value
module fwd_mux (
  input  logic [4:0]  src_addr_i,
  input  logic [31:0] reg_data_i,
  input  logic        exm_reg_write_i,
  input  logic [4:0]  exm_rd_i,
  input  logic [31:0] exm_result_i,
  input  logic        wb_reg_write_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_result_i,
  output logic [31:0] fwd_data_o
);
  import mips_pkg::*;

  // EX/MEM is the younger result, so it wins over MEM/WB.
  always_comb begin
    fwd_data_o = reg_data_i;
    if (fwdHit(exm_reg_write_i, exm_rd_i, src_addr_i)) begin
      fwd_data_o = exm_result_i;
    end else if (fwdHit(wb_reg_write_i, wb_rd_i, src_addr_i)) begin
      fwd_data_o = wb_result_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus operand forwarding for the ALU.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   id_*                     decoded instruction fields from ID
//   stall, flush             hold EX / load a bubble into EX
//   exm_*, wb_*              EX/MEM and MEM/WB writeback info for forwarding
//   alu_a, alu_b, alu_opcode ALU operand and opcode drive
//   ex_valid, ex_reg_write, ex_mem_read, ex_rd  registered controls
//   ex_store_data            forwarded rt value for stores
//   load_use_stall           load-use hazard request to upstream
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [2:0]        id_alu_op,
  input  logic [1:0]        id_src_b_sel,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_uses_rt,
  input  logic              stall,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              load_use_stall
);
  import mips_pkg::*;

  ex_regs_t          ex_q, ex_d;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  // Next EX contents: a non-valid ID slot must not leave write or load
  // side effects behind, so those controls are qualified by id_valid.
  always_comb begin
    ex_d           = '0;
    ex_d.valid     = id_valid;
    ex_d.reg_write = id_reg_write & id_valid;
    ex_d.mem_read  = id_mem_read & id_valid;
    ex_d.rd        = id_rd_addr;
    ex_d.rs_addr   = id_rs_addr;
    ex_d.rt_addr   = id_rt_addr;
    ex_d.rs_data   = id_rs_data;
    ex_d.rt_data   = id_rt_data;
    ex_d.imm       = id_imm;
    ex_d.shamt     = id_shamt;
    ex_d.op        = id_alu_op;
    ex_d.src_b_sel = srcb_e'(id_src_b_sel);
  end

  // Pipeline register: reset and flush both produce an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q <= ex_d;
    end
  end

  fwd_mux u_fwd_rs (
    .src_addr_i      (ex_q.rs_addr),
    .reg_data_i      (ex_q.rs_data),
    .exm_reg_write_i (exm_reg_write),
    .exm_rd_i        (exm_rd),
    .exm_result_i    (exm_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_result_i     (wb_result),
    .fwd_data_o      (rs_fwd)
  );

  fwd_mux u_fwd_rt (
    .src_addr_i      (ex_q.rt_addr),
    .reg_data_i      (ex_q.rt_data),
    .exm_reg_write_i (exm_reg_write),
    .exm_rd_i        (exm_rd),
    .exm_result_i    (exm_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_result_i     (wb_result),
    .fwd_data_o      (rt_fwd)
  );

  // B operand select; the reserved code falls back to rt.
  always_comb begin
    alu_b = rt_fwd;
    case (ex_q.src_b_sel)
      SRCB_IMM:   alu_b = ex_q.imm;
      SRCB_SHAMT: alu_b = {{(DATA_W-5){1'b0}}, ex_q.shamt};
      default:    alu_b = rt_fwd;
    endcase
  end

  assign alu_a         = rs_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_opcode    = ex_q.op;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_rd         = ex_q.rd;

  // A load in EX cannot forward its data in time for the instruction in ID;
  // rt only matters when the ID instruction actually reads it.
  assign load_use_stall = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                          ((ex_q.rd == id_rs_addr) |
                           (id_uses_rt & (ex_q.rd == id_rt_addr)));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: stimulus pushes predicted
// outputs into a queue, a monitor pops and compares them each cycle.
module tb_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic [2:0]  id_alu_op;
  logic [1:0]  id_src_b_sel;
  logic        id_reg_write, id_mem_read, id_uses_rt;
  logic        stall, flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_opcode;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
  logic [4:0]  ex_rd;

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt;
    logic [2:0]  op;
    logic [1:0]  sel;
    logic        rw, mr, uses_rt;
    logic        exm_we;
    logic [4:0]  exm_rd;
    logic [31:0] exm_res;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
  } stim_t;

  // Instruction currently sitting in EX, as the bench believes it to be.
  typedef struct {
    logic        valid, rw, mr;
    logic [4:0]  rd, rs, rt;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt;
    logic [2:0]  op;
    logic [1:0]  sel;
  } exinst_t;

  typedef struct {
    logic [31:0] a, b, store;
    logic [2:0]  op;
    logic        valid, rw, mr, lus;
    logic [4:0]  rd;
  } expect_t;

  ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_src_b_sel(id_src_b_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_uses_rt(id_uses_rt),
    .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  int      vectors = 0;
  int      miscompares = 0;
  expect_t expQ[$];
  exinst_t m;
  stim_t   cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t quiet();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rst     = ($urandom_range(0, 31) == 0);
    s.stall   = ($urandom_range(0, 5) == 0);
    s.flush   = ($urandom_range(0, 9) == 0);
    s.valid   = ($urandom_range(0, 3) != 0);
    s.rs      = 5'($urandom_range(0, 7));
    s.rt      = 5'($urandom_range(0, 7));
    s.rd      = 5'($urandom_range(0, 7));
    s.rs_data = $urandom;
    s.rt_data = $urandom;
    s.imm     = $urandom;
    s.shamt   = 5'($urandom);
    s.op      = 3'($urandom);
    s.sel     = 2'($urandom);
    s.rw      = 1'($urandom);
    s.mr      = 1'($urandom);
    s.uses_rt = 1'($urandom);
    s.exm_we  = 1'($urandom);
    s.exm_rd  = 5'($urandom_range(0, 7));
    s.exm_res = $urandom;
    s.wb_we   = 1'($urandom);
    s.wb_rd   = 5'($urandom_range(0, 7));
    s.wb_res  = $urandom;
    return s;
  endfunction

  task automatic driveInputs(input stim_t s);
    rst = s.rst; stall = s.stall; flush = s.flush; id_valid = s.valid;
    id_rs_addr = s.rs; id_rt_addr = s.rt; id_rd_addr = s.rd;
    id_rs_data = s.rs_data; id_rt_data = s.rt_data; id_imm = s.imm;
    id_shamt = s.shamt; id_alu_op = s.op; id_src_b_sel = s.sel;
    id_reg_write = s.rw; id_mem_read = s.mr; id_uses_rt = s.uses_rt;
    exm_reg_write = s.exm_we; exm_rd = s.exm_rd; exm_result = s.exm_res;
    wb_reg_write = s.wb_we; wb_rd = s.wb_rd; wb_result = s.wb_res;
  endtask

  // What the EX stage holds after a clock edge with inputs s.
  function automatic exinst_t nextEx(input exinst_t old, input stim_t s);
    exinst_t n;
    if (s.rst || s.flush) begin
      n = '{default: '0};
    end else if (s.stall) begin
      n = old;
    end else begin
      n.valid = s.valid; n.rw = s.rw && s.valid; n.mr = s.mr && s.valid;
      n.rd = s.rd; n.rs = s.rs; n.rt = s.rt;
      n.rs_data = s.rs_data; n.rt_data = s.rt_data; n.imm = s.imm;
      n.shamt = s.shamt; n.op = s.op; n.sel = s.sel;
    end
    return n;
  endfunction

  // Register value as seen by EX: start from the file data, then let the
  // older writer (WB) and then the younger one (EX/MEM) overwrite it.
  function automatic logic [31:0] regView(input logic [4:0] r, input logic [31:0] fileVal,
                                          input stim_t s);
    logic [31:0] v;
    v = fileVal;
    if (r != 0) begin
      if (s.wb_we && s.wb_rd == r) v = s.wb_res;
      if (s.exm_we && s.exm_rd == r) v = s.exm_res;
    end
    return v;
  endfunction

  function automatic expect_t predict(input exinst_t e, input stim_t s);
    expect_t x;
    logic [31:0] rsv, rtv;
    rsv = regView(e.rs, e.rs_data, s);
    rtv = regView(e.rt, e.rt_data, s);
    x.a = rsv;
    x.store = rtv;
    if (e.sel == 2'd1)      x.b = e.imm;
    else if (e.sel == 2'd2) x.b = 32'(e.shamt);
    else                    x.b = rtv;
    x.op = e.op; x.valid = e.valid; x.rw = e.rw; x.mr = e.mr; x.rd = e.rd;
    x.lus = e.valid && e.mr && (e.rd != 0) && s.valid &&
            ((e.rd == s.rs) || (s.uses_rt && e.rd == s.rt));
    return x;
  endfunction

  // One cycle: the edge consumes the previous inputs, then new ones go out.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    m = nextEx(m, cur);
    #1;
    cur = s;
    driveInputs(s);
    expQ.push_back(predict(m, s));
  endtask

  function automatic bit cmpField(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
    if (act !== exp) begin
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input expect_t e);
    bit ok;
    ok = 1'b1;
    ok &= cmpField("alu_a", alu_a, e.a);
    ok &= cmpField("alu_b", alu_b, e.b);
    ok &= cmpField("ex_store_data", ex_store_data, e.store);
    ok &= cmpField("alu_opcode", 32'(alu_opcode), 32'(e.op));
    ok &= cmpField("ex_valid", 32'(ex_valid), 32'(e.valid));
    ok &= cmpField("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
    ok &= cmpField("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
    ok &= cmpField("ex_rd", 32'(ex_rd), 32'(e.rd));
    ok &= cmpField("load_use_stall", 32'(load_use_stall), 32'(e.lus));
    vectors++;
    if (!ok) miscompares++;
  endtask

  // Monitor: outputs are always presented, so compare once per cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    stim_t s, add, ld, lw;
    cur = quiet();
    cur.rst = 1'b1;
    driveInputs(cur);
    m = '{default: '0};

    // reset with random ID inputs
    for (int i = 0; i < 2; i++) begin
      s = randStim(); s.rst = 1'b1; applyStimulus(s);
    end

    // ADD r3, r4 without forwarding, then with both forward sources
    add = quiet(); add.valid = 1; add.rs = 3; add.rs_data = 32'h10;
    add.rt = 4; add.rt_data = 32'h20; add.rd = 5; add.rw = 1; add.op = 3'b000;
    applyStimulus(add);
    applyStimulus(add);
    s = add; s.exm_we = 1; s.exm_rd = 3; s.exm_res = 32'hAA;
    s.wb_we = 1; s.wb_rd = 3; s.wb_res = 32'hBB;
    applyStimulus(s);
    s.wb_rd = 4; s.wb_res = 32'hCC;
    applyStimulus(s);
    s = add; s.exm_we = 1; s.exm_rd = 0; s.exm_res = 32'hFF;
    applyStimulus(s);

    // SLL with shamt operand, then ORI with immediate
    s = quiet(); s.valid = 1; s.op = 3'b001; s.sel = 2'b10; s.shamt = 5;
    s.rt = 4; s.rt_data = 32'h1234; s.rd = 6; s.rw = 1;
    applyStimulus(s);
    s = quiet(); s.valid = 1; s.op = 3'b110; s.sel = 2'b01; s.imm = 32'h0000FFFF;
    s.rs = 2; s.rs_data = 32'h5; s.rd = 8; s.rw = 1;
    applyStimulus(s);
    applyStimulus(quiet());

    // load-use detection, holding the load in EX with stall
    lw = quiet(); lw.valid = 1; lw.mr = 1; lw.rw = 1; lw.rd = 7; lw.rs = 1;
    applyStimulus(lw);
    s = quiet(); s.valid = 1; s.rs = 7; s.stall = 1;
    applyStimulus(s);
    s.rs = 1; s.rt = 7; s.uses_rt = 0;
    applyStimulus(s);
    s.uses_rt = 1;
    applyStimulus(s);
    lw.rd = 0;
    applyStimulus(lw);
    s = quiet(); s.valid = 1; s.rs = 0; s.rt = 0; s.uses_rt = 1;
    applyStimulus(s);

    // stall with forwarding tracking EX/MEM, then flush, then reset
    ld = quiet(); ld.valid = 1; ld.rs = 5; ld.rs_data = 32'h55; ld.rt = 6;
    ld.rt_data = 32'h66; ld.rd = 9; ld.rw = 1; ld.op = 3'b010;
    applyStimulus(ld);
    for (int i = 0; i < 3; i++) begin
      s = randStim(); s.rst = 0; s.flush = 0; s.stall = 1;
      s.exm_we = 1; s.exm_rd = 5; s.exm_res = $urandom;
      applyStimulus(s);
    end
    s = randStim(); s.rst = 0; s.stall = 1; s.flush = 1;
    applyStimulus(s);
    applyStimulus(ld);
    applyStimulus(quiet());
    s = randStim(); s.stall = 1; s.flush = 0; s.rst = 1;
    applyStimulus(s);
    applyStimulus(quiet());

    // randomized traffic with a small register range to provoke hazards
    for (int i = 0; i < 400; i++) applyStimulus(randStim());
    applyStimulus(quiet());

    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (expQ.size() != 0) begin
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
